// File: rtl/key_event_ctrl.sv
// key_event_ctrl: snapshots sticky keypad flags, clears them, and serialises set bits
// into a key-code FIFO while tracking the last direction key.
module key_event_ctrl #(
    parameter int DEPTH     = 4,
    parameter int KEY_UP    = 1,
    parameter int KEY_DOWN  = 9,
    parameter int KEY_LEFT  = 4,
    parameter int KEY_RIGHT = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] key_data,
    output logic        key_clear,
    output logic        ev_valid,
    output logic [3:0]  ev_code,
    input  logic        ev_ready,
    output logic [1:0]  dir,
    output logic        dir_valid,
    output logic        ovf,
    input  logic        ovf_clr,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [3:0] C_UP    = 4'(KEY_UP);
    localparam logic [3:0] C_DOWN  = 4'(KEY_DOWN);
    localparam logic [3:0] C_LEFT  = 4'(KEY_LEFT);
    localparam logic [3:0] C_RIGHT = 4'(KEY_RIGHT);

    typedef enum logic [1:0] {IDLE, CLR, SCAN} state_t;

    state_t      r_state;
    logic [15:0] r_snap;
    logic [3:0]  r_idx;
    logic        r_key_clear;
    logic        r_busy;
    logic [1:0]  r_dir;
    logic        r_dir_valid;
    logic        r_ovf;
    logic [3:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_wr;
    logic       w_match;
    logic [1:0] w_dir;

    assign w_push  = (r_state == SCAN) && r_snap[r_idx];
    assign w_full  = (r_cnt == CNT_FULL);
    assign w_pop   = ev_valid && ev_ready;
    assign w_wr    = w_push && !w_full;
    assign w_match = (r_idx == C_UP) || (r_idx == C_DOWN) || (r_idx == C_LEFT) || (r_idx == C_RIGHT);
    assign w_dir   = (r_idx == C_UP)   ? 2'd0 :
                     (r_idx == C_DOWN) ? 2'd1 :
                     (r_idx == C_LEFT) ? 2'd2 : 2'd3;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_snap      <= 16'd0;
            r_idx       <= 4'd0;
            r_key_clear <= 1'b0;
            r_busy      <= 1'b0;
            r_dir       <= 2'd0;
            r_dir_valid <= 1'b0;
        end else begin
            r_key_clear <= 1'b0;
            case (r_state)
                IDLE: if (key_data != 16'd0) begin
                    r_snap      <= key_data;
                    r_key_clear <= 1'b1;
                    r_busy      <= 1'b1;
                    r_state     <= CLR;
                end
                CLR: begin
                    r_idx   <= 4'd0;
                    r_state <= SCAN;
                end
                SCAN: begin
                    // direction tracks every matching set bit, even when the push is dropped
                    if (r_snap[r_idx] && w_match) begin
                        r_dir       <= w_dir;
                        r_dir_valid <= 1'b1;
                    end
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == 4'd15) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 4'd0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= r_idx;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            // a drop in the same cycle as ovf_clr keeps the flag set
            if (w_push && w_full) r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    assign key_clear = r_key_clear;
    assign busy      = r_busy;
    assign dir       = r_dir;
    assign dir_valid = r_dir_valid;
    assign ovf       = r_ovf;
    assign ev_valid  = (r_cnt != '0);
    assign ev_code   = r_mem[r_rp];
endmodule
